// File: rtl/ram_dp_sync_clr.sv
// 1W1R synchronous RAM with per-lane write mask and a one-word-per-cycle clear sequencer.
// Define RAM_DP_SYNC_CLR_BYPASS_EN to forward same-address write data to the read port.
module ram_dp_sync_clr #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    LANE_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0,
  localparam int                   NUM_LANES  = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_LANES-1:0]  wr_mask,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  clr_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(RAM_DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
  logic                  arm_q, arm_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic clearing, clr_we, wr_acc, rd_acc, wr_in_range, rd_in_range;
  logic [NUM_LANES-1:0][LANE_WIDTH-1:0] rd_lanes;

  // arm_q stands in for the IDLE->CLEAR hop on reset release so busy rises
  // in the very first cycle after rst falls.
  assign clearing    = arm_q || (state_q == CLEAR);
  assign busy        = clearing && !rst;
  assign clr_we      = busy;
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  assign wr_acc      = wr_en && !busy && !rst && wr_in_range;
  assign rd_acc      = rd_en && !busy && !rst;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    arm_d     = 1'b0;
    if (clearing) begin
      state_d   = CLEAR;
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_ADDR) begin
        state_d   = IDLE;
        clr_cnt_d = '0;
      end
    end else if (clr_req) begin
      state_d = CLEAR;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LANE_WIDTH-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
      if (clr_we)
        mem[clr_cnt_q[ADDR_WIDTH-1:0]] <= CLR_VALUE[l*LANE_WIDTH +: LANE_WIDTH];
      else if (wr_acc && wr_mask[l])
        mem[wr_addr] <= wr_data[l*LANE_WIDTH +: LANE_WIDTH];
    end

`ifdef RAM_DP_SYNC_CLR_BYPASS_EN
    assign rd_lanes[l] = (wr_acc && wr_mask[l] && (wr_addr == rd_addr))
                       ? wr_data[l*LANE_WIDTH +: LANE_WIDTH] : mem[rd_addr];
`else
    assign rd_lanes[l] = mem[rd_addr];
`endif
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (rd_acc) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_in_range ? rd_lanes : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      arm_q      <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      arm_q      <= arm_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_dp_sync_clr.sv
// Directed + randomized bench for ram_dp_sync_clr against a countdown-based reference model.
module tb_ram_dp_sync_clr;
  localparam int          DW    = 16;
  localparam int          LW    = 8;
  localparam int          AW    = 4;
  localparam int          DEPTH = 12;
  localparam logic [15:0] CLR   = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_mask = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        clr_req = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;

  ram_dp_sync_clr #(
    .DATA_WIDTH(DW), .LANE_WIDTH(LW), .ADDR_WIDTH(AW),
    .RAM_DEPTH(DEPTH), .CLR_VALUE(CLR)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .rd_en(rd_en), .rd_addr(rd_addr), .clr_req(clr_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] mem_m [DEPTH];
  int          clr_left = 0;
  logic [15:0] exp_data = '0;
  logic        exp_valid = 1'b0;
  logic        obs_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check busy for this cycle, advance model, check registered outputs.
  task automatic step(input logic r, input logic we, input logic [3:0] wa, input logic [15:0] wd,
                      input logic [1:0] wm, input logic re, input logic [3:0] ra, input logic cr);
    logic exp_busy;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
    rd_en = re; rd_addr = ra; clr_req = cr;
    exp_busy = !r && (clr_left > 0);
    #1;
    obs_busy = busy;
    chk("busy", busy, exp_busy);
    if (r) begin
      exp_data = '0; exp_valid = 1'b0; clr_left = DEPTH;
    end else if (clr_left > 0) begin
      mem_m[DEPTH - clr_left] = CLR;
      clr_left--;
      exp_valid = 1'b0;
    end else begin
      exp_valid = re;
      if (re) begin
        if (ra < DEPTH) begin
          exp_data = mem_m[ra];
`ifdef RAM_DP_SYNC_CLR_BYPASS_EN
          if (we && wa == ra)
            for (int l = 0; l < 2; l++) if (wm[l]) exp_data[l*LW +: LW] = wd[l*LW +: LW];
`endif
        end else begin
          exp_data = '0;
        end
      end
      if (we && wa < DEPTH)
        for (int l = 0; l < 2; l++) if (wm[l]) mem_m[wa][l*LW +: LW] = wd[l*LW +: LW];
      if (cr) clr_left = DEPTH;
    end
    @(posedge clk); #1;
    chk("rd_valid", rd_valid, exp_valid);
    chk("rd_data", rd_data, exp_data);
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
    step(0, 1, a, d, m, 0, 0, 0);
  endtask
  task automatic rd(input logic [3:0] a); step(0, 0, 0, 0, 0, 1, a, 0); endtask

  // Bounded run that counts busy cycles; optional second clr_req at step cr_at.
  task automatic count_busy(input string tag, input int cr_at);
    int n = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      step(0, 1, 4'(i), 16'h5A5A, 2'b11, 1, 4'(i % DEPTH), (i == cr_at));
      if (obs_busy) n++;
    end
    chk(tag, n, DEPTH);
  endtask

  task automatic read_all(input string tag, input logic chk_clr);
    for (int a = 0; a < DEPTH; a++) begin
      rd(4'(a));
      if (chk_clr) chk(tag, rd_data, CLR);
    end
  endtask

  initial begin
    // Reset state and clear after release
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 2, 16'hFFFF, 2'b11, 1, 2, 0);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_data", rd_data, 16'h0000);
    count_busy("busy_after_rst", -1);
    read_all("post_rst_clr", 1'b1);

    // Masked writes
    wr(3, 16'h1234, 2'b11);
    wr(3, 16'hFFFF, 2'b01);
    rd(3);
    chk("mask_merge", rd_data, 16'h12FF);

    // Same-address read during write
    wr(5, 16'h0000, 2'b11);
    step(0, 1, 5, 16'hBEEF, 2'b11, 1, 5, 0);
`ifdef RAM_DP_SYNC_CLR_BYPASS_EN
    chk("rdw_same_addr", rd_data, 16'hBEEF);
`else
    chk("rdw_same_addr", rd_data, 16'h0000);
`endif
    rd(5);
    chk("rdw_followup", rd_data, 16'hBEEF);

    // Out-of-range accesses
    rd(14);
    chk("oor_rd_valid", rd_valid, 1'b1);
    chk("oor_rd_data", rd_data, 16'h0000);
    wr(13, 16'h7777, 2'b11);
    read_all("oor_wr", 1'b0);

    // clr_req with read in the same cycle, then ignored second clr_req
    step(0, 0, 0, 0, 0, 1, 3, 1);
    chk("pre_clear_read", rd_data, 16'h12FF);
    count_busy("busy_clr_req", 3);
    read_all("post_clr_req", 1'b1);

    // Reset mid-clear restarts from address 0
    wr(7, 16'h0102, 2'b11);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) idle();
    step(1, 0, 0, 0, 0, 1, 0, 0);
    chk("midclr_rst_valid", rd_valid, 1'b0);
    count_busy("busy_after_abort", -1);
    read_all("post_abort", 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) == 0), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
           16'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
           4'($urandom_range(0, 15)), ($urandom_range(0, 49) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) idle();
    read_all("final", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_dp_sync_clr.md
RAM_DP_SYNC_CLR -- requirements
Module: ram_dp_sync_clr

Interface
REQ-001 Parameter DATA_WIDTH, default 8: word width in bits; SHALL be a multiple of LANE_WIDTH.
REQ-002 Parameter LANE_WIDTH, default 8: bits per write-mask lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
REQ-003 Parameter ADDR_WIDTH, default 8: address width.
REQ-004 Parameter RAM_DEPTH, default 1<<ADDR_WIDTH: number of words, 1..2^ADDR_WIDTH.
REQ-005 Parameter CLR_VALUE, default 0: DATA_WIDTH-bit fill pattern written by the clear sequencer.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 wr_en  in  1  write request.
REQ-009 wr_addr  in  ADDR_WIDTH  write address.
REQ-010 wr_data  in  DATA_WIDTH  write data.
REQ-011 wr_mask  in  NUM_LANES  per-lane write enable; bit i covers wr_data[i*LANE_WIDTH +: LANE_WIDTH].
REQ-012 rd_en  in  1  read request.
REQ-013 rd_addr  in  ADDR_WIDTH  read address.
REQ-014 clr_req  in  1  single-cycle pulse requesting a full-array clear.
REQ-015 rd_data  out  DATA_WIDTH  registered read data.
REQ-016 rd_valid  out  1  rd_data updated this cycle.
REQ-017 busy  out  1  clear sequencer active; user ports ignored.

Function
REQ-018 Write and read ports SHALL operate independently in the same cycle (1W1R).
REQ-019 Accepted write (wr_en=1, busy=0, wr_addr<RAM_DEPTH) SHALL update only lanes with wr_mask=1 at the clock edge; other lanes retain their value.
REQ-020 Accepted read (rd_en=1, busy=0) SHALL present data on rd_data with rd_valid=1 exactly one cycle later.
REQ-021 When no read is accepted, rd_valid SHALL be 0 the next cycle and rd_data SHALL hold its previous value.
REQ-022 Read with rd_addr>=RAM_DEPTH SHALL return all-zero data with rd_valid=1; write with wr_addr>=RAM_DEPTH SHALL be dropped.
REQ-023 Sequencer states IDLE and CLEAR; IDLE->CLEAR on rst deassertion or on clr_req=1 in IDLE.
REQ-024 In CLEAR, one word per cycle SHALL be written with CLR_VALUE at addresses 0..RAM_DEPTH-1 ascending; CLEAR->IDLE after address RAM_DEPTH-1 is written.
REQ-025 busy SHALL be 1 in every cycle in CLEAR, so a full clear takes exactly RAM_DEPTH busy cycles; busy SHALL be 0 in IDLE.
REQ-026 clr_req while in CLEAR SHALL be ignored; the sequencer SHALL neither restart nor extend.
REQ-027 User wr_en/rd_en while busy=1 SHALL be dropped, with no memory change and rd_valid=0 next cycle.
REQ-028 Read started the cycle before CLEAR is entered SHALL complete normally with its pre-clear data.
REQ-029 Clear counter width SHALL be ADDR_WIDTH+1 so that RAM_DEPTH=2^ADDR_WIDTH terminates without wrap-around.

Reset
REQ-030 While rst=1: rd_data=0, rd_valid=0, busy=0, sequencer=IDLE, clear counter=0; memory contents are unspecified.
REQ-031 First cycle after rst falls, the sequencer SHALL enter CLEAR, so busy=1 in that cycle.
REQ-032 rst asserted mid-CLEAR SHALL abort the clear; after release the clear SHALL restart from address 0.

Configuration
REQ-033 Macro RAM_DP_SYNC_CLR_BYPASS_EN selects same-address read-during-write behaviour.
REQ-034 Defined: a read and an accepted write to the same address in one cycle SHALL return the masked merge, with new data on written lanes and old data elsewhere.
REQ-035 Undefined: the same case SHALL return the old contents (read-before-write); the write still completes.

Verification (DATA_WIDTH=16, LANE_WIDTH=8, ADDR_WIDTH=4, RAM_DEPTH=12, CLR_VALUE=16'hA5A5)
REQ-036 Release rst -> busy=1 for exactly 12 cycles; afterwards reads of addresses 0..11 each return 16'hA5A5 one cycle later with rd_valid=1.
REQ-037 Write 16'h1234 mask 2'b11 to addr 3, then 16'hFFFF mask 2'b01 to addr 3, then read addr 3 -> rd_data=16'h12FF.
REQ-038 With addr 5=16'h0000, write 16'hBEEF mask 2'b11 to addr 5 and read addr 5 in the same cycle -> 16'hBEEF with macro, 16'h0000 without; a subsequent read returns 16'hBEEF.
REQ-039 Read addr 14 -> rd_data=0, rd_valid=1; write 16'h7777 to addr 13, then read every address 0..11 -> all unchanged.
REQ-040 clr_req pulsed, then again after 4 cycles -> busy=1 for exactly 12 cycles; rd_en during busy -> rd_valid=0; all words 16'hA5A5 afterwards.
REQ-041 rst asserted for 1 cycle at clear cycle 6 -> rd_valid=0 and busy=0 during rst; busy=1 for 12 further cycles after release; all words 16'hA5A5.
